// File: rtl/branch_update_queue.sv
`default_nettype none
// ============================================================================
//  Module   : branch_update_queue
//  Purpose  : Buffers up to two resolved branches per cycle and drains them in
//             program order to the local-history predictor update ports.
//  Revision : 1.0  initial release
// ============================================================================
module branch_update_queue #(
    parameter int DEPTH         = 8,
    parameter int LOCALTAB_SIZE = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_br1_valid,
    input  logic [63:0] ex_br1_pc,
    input  logic        ex_br1_taken,
    input  logic        ex_br2_valid,
    input  logic [63:0] ex_br2_pc,
    input  logic        ex_br2_taken,
    input  logic        upd_stall,
    output logic        branch_valid1,
    output logic [63:0] branch_pc1,
    output logic        branch_result1,
    output logic        branch_valid2,
    output logic [63:0] branch_pc2,
    output logic        branch_result2,
    output logic        queue_full,
    output logic        overflow
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_IDX_HI = $clog2(LOCALTAB_SIZE) + 1;

    logic [63:0]        r_pc [DEPTH];
    logic [DEPTH-1:0]   r_taken;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;

    logic [c_CNT_W-1:0] w_free;
    logic [c_PTR_W-1:0] w_head_p1;
    logic [c_PTR_W-1:0] w_wr2_ptr;
    logic               w_acc1;
    logic               w_acc2;
    logic               w_drop;
    logic               w_deq1;
    logic               w_deq2;
    logic [1:0]         w_n_enq;
    logic [1:0]         w_n_deq;

    assign w_free    = c_CNT_W'(DEPTH) - r_count;
    assign w_head_p1 = r_head + c_PTR_W'(1);

    // Space is judged on the registered count only; same-cycle drains do not free slots.
    always_comb begin
        w_acc1    = ex_br1_valid && (w_free >= c_CNT_W'(1));
        w_acc2    = ex_br2_valid && (w_free >= (ex_br1_valid ? c_CNT_W'(2) : c_CNT_W'(1)));
        w_drop    = (ex_br1_valid && !w_acc1) || (ex_br2_valid && !w_acc2);
        w_n_enq   = {1'b0, w_acc1} + {1'b0, w_acc2};
        w_wr2_ptr = w_acc1 ? (r_tail + c_PTR_W'(1)) : r_tail;
    end

    // A same-index pair is split so the predictor never sees two updates to one entry.
    always_comb begin
        w_deq1  = (r_count >= c_CNT_W'(1)) && !upd_stall;
        w_deq2  = (r_count >= c_CNT_W'(2)) && !upd_stall &&
                  (r_pc[w_head_p1][c_IDX_HI:2] != r_pc[r_head][c_IDX_HI:2]);
        w_n_deq = {1'b0, w_deq1} + {1'b0, w_deq2};
    end

    assign branch_valid1  = w_deq1;
    assign branch_pc1     = w_deq1 ? r_pc[r_head] : 64'd0;
    assign branch_result1 = w_deq1 & r_taken[r_head];
    assign branch_valid2  = w_deq2;
    assign branch_pc2     = w_deq2 ? r_pc[w_head_p1] : 64'd0;
    assign branch_result2 = w_deq2 & r_taken[w_head_p1];
    assign queue_full     = (w_free < c_CNT_W'(2));
    assign overflow       = r_overflow;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head  <= r_head + c_PTR_W'(w_n_deq);
            r_tail  <= r_tail + c_PTR_W'(w_n_enq);
            r_count <= r_count + c_CNT_W'(w_n_enq) - c_CNT_W'(w_n_deq);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (w_acc1) begin
            r_pc[r_tail]    <= ex_br1_pc;
            r_taken[r_tail] <= ex_br1_taken;
        end
        if (w_acc2) begin
            r_pc[w_wr2_ptr]    <= ex_br2_pc;
            r_taken[w_wr2_ptr] <= ex_br2_taken;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_update_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_update_queue
//  Purpose  : Self-checking bench: directed vector table, corner sequences and
//             random traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_update_queue;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_br1_valid;
    logic [63:0] ex_br1_pc;
    logic        ex_br1_taken;
    logic        ex_br2_valid;
    logic [63:0] ex_br2_pc;
    logic        ex_br2_taken;
    logic        upd_stall;
    logic        branch_valid1;
    logic [63:0] branch_pc1;
    logic        branch_result1;
    logic        branch_valid2;
    logic [63:0] branch_pc2;
    logic        branch_result2;
    logic        queue_full;
    logic        overflow;

    branch_update_queue #(.DEPTH(DEPTH), .LOCALTAB_SIZE(16)) dut (
        .clock(clock), .reset(reset),
        .ex_br1_valid(ex_br1_valid), .ex_br1_pc(ex_br1_pc), .ex_br1_taken(ex_br1_taken),
        .ex_br2_valid(ex_br2_valid), .ex_br2_pc(ex_br2_pc), .ex_br2_taken(ex_br2_taken),
        .upd_stall(upd_stall),
        .branch_valid1(branch_valid1), .branch_pc1(branch_pc1), .branch_result1(branch_result1),
        .branch_valid2(branch_valid2), .branch_pc2(branch_pc2), .branch_result2(branch_result2),
        .queue_full(queue_full), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] pc;
        logic        taken;
    } ent_t;

    ent_t mq[$];
    logic m_ovf;

    typedef struct {
        logic v1; logic [63:0] p1; logic t1;
        logic v2; logic [63:0] p2; logic t2;
        logic st;
        logic ev1; logic [63:0] ep1; logic er1;
        logic ev2; logic [63:0] ep2; logic er2;
    } vec_t;

    vec_t vt[13];

    logic [63:0] rp1, rp2;

    function automatic logic [3:0] idx(input logic [63:0] pc);
        return pc[5:2];
    endfunction

    function automatic vec_t mk(input logic v1, input logic [63:0] p1, input logic t1,
                                input logic v2, input logic [63:0] p2, input logic t2,
                                input logic st,
                                input logic ev1, input logic [63:0] ep1, input logic er1,
                                input logic ev2, input logic [63:0] ep2, input logic er2);
        vec_t v;
        v.v1 = v1; v.p1 = p1; v.t1 = t1; v.v2 = v2; v.p2 = p2; v.t2 = t2; v.st = st;
        v.ev1 = ev1; v.ep1 = ep1; v.er1 = er1; v.ev2 = ev2; v.ep2 = ep2; v.er2 = er2;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of head entries the model drains this cycle.
    function automatic int model_ndeq();
        if (upd_stall || mq.size() == 0) return 0;
        if (mq.size() >= 2 && idx(mq[0].pc) != idx(mq[1].pc)) return 2;
        return 1;
    endfunction

    task automatic check_model();
        int          n;
        logic        ev1, ev2, er1, er2;
        logic [63:0] ep1, ep2;
        n   = model_ndeq();
        ev1 = (n >= 1);
        ev2 = (n == 2);
        ep1 = ev1 ? mq[0].pc : 64'd0;
        er1 = ev1 ? mq[0].taken : 1'b0;
        ep2 = ev2 ? mq[1].pc : 64'd0;
        er2 = ev2 ? mq[1].taken : 1'b0;
        chk1 ("mdl_valid1",  branch_valid1,  ev1);
        chk64("mdl_pc1",     branch_pc1,     ep1);
        chk1 ("mdl_result1", branch_result1, er1);
        chk1 ("mdl_valid2",  branch_valid2,  ev2);
        chk64("mdl_pc2",     branch_pc2,     ep2);
        chk1 ("mdl_result2", branch_result2, er2);
        chk1 ("mdl_full",    queue_full,     (DEPTH - mq.size()) < 2);
        chk1 ("mdl_overflow", overflow,      m_ovf);
    endtask

    task automatic model_edge();
        int   n;
        int   free_slots;
        ent_t e;
        n          = model_ndeq();
        free_slots = DEPTH - mq.size();
        repeat (n) mq.delete(0);
        if (ex_br1_valid) begin
            if (free_slots > 0) begin
                e.pc = ex_br1_pc; e.taken = ex_br1_taken;
                mq.push_back(e);
                free_slots--;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (ex_br2_valid) begin
            if (free_slots > 0) begin
                e.pc = ex_br2_pc; e.taken = ex_br2_taken;
                mq.push_back(e);
                free_slots--;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic v1, input logic [63:0] p1, input logic t1,
                       input logic v2, input logic [63:0] p2, input logic t2,
                       input logic st);
        ex_br1_valid = v1; ex_br1_pc = p1; ex_br1_taken = t1;
        ex_br2_valid = v2; ex_br2_pc = p2; ex_br2_taken = t2;
        upd_stall    = st;
        @(negedge clock);
        check_model();
    endtask

    task automatic adv();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
            adv();
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk1 ({name, "_valid1"},  branch_valid1,  1'b0);
        chk64({name, "_pc1"},     branch_pc1,     64'd0);
        chk1 ({name, "_result1"}, branch_result1, 1'b0);
        chk1 ({name, "_valid2"},  branch_valid2,  1'b0);
        chk64({name, "_pc2"},     branch_pc2,     64'd0);
        chk1 ({name, "_result2"}, branch_result2, 1'b0);
        chk1 ({name, "_full"},    queue_full,     1'b0);
        chk1 ({name, "_overflow"}, overflow,      1'b0);
    endtask

    initial begin
        reset = 1'b0;
        ex_br1_valid = 1'b0; ex_br1_pc = '0; ex_br1_taken = 1'b0;
        ex_br2_valid = 1'b0; ex_br2_pc = '0; ex_br2_taken = 1'b0;
        upd_stall = 1'b0;
        m_ovf = 1'b0;

        // Directed vectors: pair drain, same-index split, stall hold.
        vt[0]  = mk(1, 64'h100, 1, 1, 64'h204, 0, 0,  0, 64'h0,   0, 0, 64'h0,   0);
        vt[1]  = mk(0, 64'h0,   0, 0, 64'h0,   0, 0,  1, 64'h100, 1, 1, 64'h204, 0);
        vt[2]  = mk(0, 64'h0,   0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 0, 64'h0,   0);
        vt[3]  = mk(1, 64'h100, 1, 1, 64'h140, 1, 0,  0, 64'h0,   0, 0, 64'h0,   0);
        vt[4]  = mk(0, 64'h0,   0, 0, 64'h0,   0, 0,  1, 64'h100, 1, 0, 64'h0,   0);
        vt[5]  = mk(0, 64'h0,   0, 0, 64'h0,   0, 0,  1, 64'h140, 1, 0, 64'h0,   0);
        vt[6]  = mk(0, 64'h0,   0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 0, 64'h0,   0);
        vt[7]  = mk(1, 64'h208, 0, 1, 64'h30C, 1, 1,  0, 64'h0,   0, 0, 64'h0,   0);
        vt[8]  = mk(0, 64'h0,   0, 0, 64'h0,   0, 1,  0, 64'h0,   0, 0, 64'h0,   0);
        vt[9]  = mk(0, 64'h0,   0, 0, 64'h0,   0, 1,  0, 64'h0,   0, 0, 64'h0,   0);
        vt[10] = mk(0, 64'h0,   0, 0, 64'h0,   0, 1,  0, 64'h0,   0, 0, 64'h0,   0);
        vt[11] = mk(0, 64'h0,   0, 0, 64'h0,   0, 0,  1, 64'h208, 0, 1, 64'h30C, 1);
        vt[12] = mk(0, 64'h0,   0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 0, 64'h0,   0);

        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("rst");
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].v1, vt[i].p1, vt[i].t1, vt[i].v2, vt[i].p2, vt[i].t2, vt[i].st);
            chk1 ("tbl_valid1",  branch_valid1,  vt[i].ev1);
            chk64("tbl_pc1",     branch_pc1,     vt[i].ep1);
            chk1 ("tbl_result1", branch_result1, vt[i].er1);
            chk1 ("tbl_valid2",  branch_valid2,  vt[i].ev2);
            chk64("tbl_pc2",     branch_pc2,     vt[i].ep2);
            chk1 ("tbl_result2", branch_result2, vt[i].er2);
            adv();
        end

        // Fill under stall, then a pair arriving with one free slot.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 64'h1000 + 64'(8 * k), 1'b1, 1'b1, 64'h1004 + 64'(8 * k), 1'b0, 1'b1);
            adv();
        end
        cyc(1'b1, 64'h1018, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk1("fill6_full", queue_full, 1'b0);
        adv();
        cyc(1'b1, 64'h101C, 1'b1, 1'b1, 64'h1020, 1'b1, 1'b1);
        chk1("fill7_full", queue_full, 1'b1);
        chk1("fill7_ovf",  overflow,   1'b0);
        adv();
        cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk1("fill8_full", queue_full, 1'b1);
        chk1("fill8_ovf",  overflow,   1'b1);
        adv();
        idle(6);
        cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk1("ovf_sticky", overflow, 1'b1);
        adv();

        // Asynchronous reset with the queue half full.
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 64'h2000 + 64'(8 * k), 1'b1, 1'b1, 64'h2004 + 64'(8 * k), 1'b1, 1'b1);
            adv();
        end
        ex_br1_valid = 1'b0; ex_br2_valid = 1'b0; upd_stall = 1'b0;
        #2;
        chk1("pre_rst_valid1", branch_valid1, 1'b1);
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        mq.delete();
        m_ovf = 1'b0;
        @(posedge clock);
        #1;
        chk_all_zero("in_rst");
        reset = 1'b1;
        @(negedge clock);
        check_model();
        @(posedge clock);
        model_edge();
        #1;
        cyc(1'b1, 64'h500, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        adv();
        cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk1 ("post_rst_valid1", branch_valid1, 1'b1);
        chk1 ("post_rst_valid2", branch_valid2, 1'b0);
        chk64("post_rst_pc1",    branch_pc1,    64'h500);
        adv();
        idle(1);

        // Continuous two-in/two-out traffic across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 64'(32'hA000 + i * 256 + ((2 * i) % 16) * 4), i[0],
                1'b1, 64'(32'hA080 + i * 256 + ((2 * i + 1) % 16) * 4), ~i[0], 1'b0);
            chk1("wrap_ovf",  overflow,   1'b0);
            chk1("wrap_full", queue_full, 1'b0);
            adv();
        end
        idle(3);

        // Random traffic with frequent index collisions and stalls.
        for (int i = 0; i < 400; i++) begin
            rp1 = {$urandom, $urandom};
            rp2 = {$urandom, $urandom};
            rp1[5:2] = 4'($urandom_range(0, 3));
            rp2[5:2] = 4'($urandom_range(0, 3));
            cyc($urandom_range(0, 9) < 6, rp1, 1'($urandom),
                $urandom_range(0, 9) < 6, rp2, 1'($urandom),
                $urandom_range(0, 3) == 0);
            adv();
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
